// File: rtl/ov7670_capture_scaled.sv
// ov7670_capture_scaled
//   Captures OV7670 RGB565 byte pairs in the camera PCLK domain and emits
//   frame-buffer writes. Decimation by 1, 2 or 4 on both axes still produces
//   dense, linear write addresses. A capture is armed only at a frame boundary.
//   Each captured frame is counted and ends with a one-cycle done pulse. A line
//   whose byte count is not exactly 2*H_ACTIVE sets a sticky error flag.
//
// Ports
//   clk          camera PCLK; all logic runs on the rising edge
//   reset        synchronous, active-high
//   enable       capture arm, sampled only at frame boundaries
//   scale        0 = full, 1 = 1/2, 2 = 1/4 per axis, 3 = full; latched at frame start
//   vsync        sensor VSYNC, high between frames
//   href         sensor HREF, high during active line bytes
//   d            sensor data byte
//   we           frame-buffer write strobe, one cycle per written pixel
//   addr         write address, dense from 0 within each frame
//   dout         write pixel (RGB444 when OUT_BITS = 12, RGB565 when OUT_BITS = 16)
//   frame_done   one-cycle pulse at the end of each captured frame
//   frame_count  captured frames, wraps 65535 -> 0
//   line_err     sticky bad-line-length flag, cleared only by reset
//   dbg_state    current FSM state (0 = IDLE, 1 = SYNC, 2 = ACTIVE)
//
// Handshake: there is no back-pressure. The sink must accept a write on
// every cycle in which we = 1. addr and dout are valid only in those cycles.
module ov7670_capture_scaled #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OUT_BITS = 12,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          scale,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          d,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [OUT_BITS-1:0] dout,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                line_err,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [15:0] X_LIM      = 16'(H_ACTIVE);
  localparam logic [15:0] Y_LIM      = 16'(V_ACTIVE);
  localparam logic [15:0] LINE_BYTES = 16'(2 * H_ACTIVE);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t state, state_next;

  logic              vsync_q, href_q;
  logic              vsync_rise, vsync_fall, href_fall;
  logic [15:0]       x, y, bcnt;
  logic              phase;
  logic [7:0]        hi;
  logic [1:0]        smask;        // low bits of x/y that must be zero to write
  logic [ADDR_W-1:0] wr_addr;
  logic [OUT_BITS-1:0] pix;

  logic start_frame, end_frame, byte_en, line_end, write_ok;

  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;
  assign href_fall  = ~href & href_q;
  assign dbg_state  = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A frame already under way when capture is armed is
  // skipped: IDLE waits for VSYNC high, then SYNC waits for its falling edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && vsync) state_next = SYNC;
      SYNC:    if (vsync_fall) state_next = ACTIVE;
      ACTIVE:  if (vsync_rise) state_next = enable ? SYNC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode. A VSYNC rise wins over any byte or line-end activity in
  // the same cycle. A truncated line therefore neither writes its partial
  // pixel nor raises line_err.
  always_comb begin
    start_frame = 1'b0;
    end_frame   = 1'b0;
    byte_en     = 1'b0;
    line_end    = 1'b0;
    case (state)
      SYNC:   start_frame = vsync_fall;
      ACTIVE: begin
        end_frame = vsync_rise;
        byte_en   = href & ~vsync_rise;
        line_end  = href_fall & ~vsync_rise;
      end
      default: ;
    endcase
  end

  // x is the index of the pixel being completed, before it increments.
  assign write_ok = byte_en & phase & (x < X_LIM) & (y < Y_LIM) &
                    ((x[1:0] & smask) == 2'b00) & ((y[1:0] & smask) == 2'b00);

  // Pixel formatting from {hi, lo}: hi = {R[4:0], G[5:3]}, lo = {G[2:0], B[4:0]}.
  generate
    if (OUT_BITS == 16) begin : g_rgb565
      assign pix = {hi, d};
    end else begin : g_rgb444
      logic unused_bits;
      assign pix         = {hi[7:4], hi[2:0], d[7], d[4:1]};
      assign unused_bits = ^{hi[3], d[6:5], d[0]};
    end
  endgenerate

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      x           <= '0;
      y           <= '0;
      bcnt        <= '0;
      phase       <= 1'b0;
      hi          <= '0;
      smask       <= 2'b00;
      wr_addr     <= '0;
      we          <= 1'b0;
      addr        <= '0;
      dout        <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      line_err    <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      href_q     <= href;
      we         <= 1'b0;
      frame_done <= 1'b0;

      if (start_frame) begin
        case (scale)
          2'd1:    smask <= 2'b01;
          2'd2:    smask <= 2'b11;
          default: smask <= 2'b00;
        endcase
        x       <= '0;
        y       <= '0;
        bcnt    <= '0;
        phase   <= 1'b0;
        wr_addr <= '0;
      end

      if (end_frame) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
        phase       <= 1'b0;
      end

      // Counters saturate so an overlong line cannot wrap back into range.
      if (byte_en) begin
        if (bcnt != CNT_MAX) bcnt <= bcnt + 16'd1;
        if (!phase) begin
          hi    <= d;
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (x != CNT_MAX) x <= x + 16'd1;
        end
      end

      // An odd trailing byte is dropped by clearing the phase here.
      if (line_end) begin
        if (bcnt != LINE_BYTES) line_err <= 1'b1;
        if (y != CNT_MAX) y <= y + 16'd1;
        x     <= '0;
        bcnt  <= '0;
        phase <= 1'b0;
      end

      if (write_ok) begin
        we      <= 1'b1;
        addr    <= wr_addr;
        dout    <= pix;
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture_scaled.sv
// Bench for ov7670_capture_scaled. A 12-bit and a 16-bit instance share the
// same sensor stimulus. Each expected write is queued with the cycle in which
// it must appear and its address and pixel. A negedge monitor pops and
// compares every write. Frame status is checked at each VSYNC pulse.
module tb_ov7670_capture_scaled;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 19;

  logic        clk = 1'b0;
  logic        reset, enable, vsync, href;
  logic [1:0]  scale;
  logic [7:0]  d;
  logic        we12, we16, fd12, fd16, le12, le16;
  logic [AW-1:0] addr12, addr16;
  logic [11:0] dout12;
  logic [15:0] dout16, fc12, fc16;
  logic [1:0]  st12, st16;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ov7670_capture_scaled #(.H_ACTIVE(H), .V_ACTIVE(V), .OUT_BITS(12), .ADDR_W(AW)) dut12 (
    .clk(clk), .reset(reset), .enable(enable), .scale(scale), .vsync(vsync),
    .href(href), .d(d), .we(we12), .addr(addr12), .dout(dout12),
    .frame_done(fd12), .frame_count(fc12), .line_err(le12), .dbg_state(st12));

  ov7670_capture_scaled #(.H_ACTIVE(H), .V_ACTIVE(V), .OUT_BITS(16), .ADDR_W(AW)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .scale(scale), .vsync(vsync),
    .href(href), .d(d), .we(we16), .addr(addr16), .dout(dout16),
    .frame_done(fd16), .frame_count(fc16), .line_err(le16), .dbg_state(st16));

  // Scoreboard: {cycle[31:0], addr[18:0], data[15:0]}
  logic [66:0] exp12_q[$];
  logic [66:0] exp16_q[$];
  logic [66:0] e12, e16;
  int checks = 0;
  int passed = 0;
  int fd_seen12 = 0, fd_seen16 = 0, fd_exp = 0;

  // Bench-side expectations
  bit          cap = 1'b0;
  int          s_div = 1;
  int          exp_addr = 0;
  logic [15:0] fc = 16'd0;
  bit          le = 1'b0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (fd12) fd_seen12++;
    if (fd16) fd_seen16++;
    if (we12) begin
      if (exp12_q.size() == 0) begin
        checks++;
        $display("FAIL wr12_unexpected: addr %0d dout %0h, nothing expected", addr12, dout12);
      end else begin
        e12 = exp12_q.pop_front();
        check("wr12", {32'(cyc), addr12, 4'h0, dout12}, e12);
      end
    end
    if (we16) begin
      if (exp16_q.size() == 0) begin
        checks++;
        $display("FAIL wr16_unexpected: addr %0d dout %0h, nothing expected", addr16, dout16);
      end else begin
        e16 = exp16_q.pop_front();
        check("wr16", {32'(cyc), addr16, dout16}, e16);
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] b);
    @(posedge clk); #1;
    vsync = v; href = h; d = b;
  endtask

  function automatic logic [7:0] pat_byte(input int pat, input int y, input int x, input int ph);
    case (pat)
      0:       return (ph != 0) ? 8'h1F : 8'hF8;
      2:       return (ph != 0) ? 8'hCD : 8'hAB;
      default: return (ph != 0) ? 8'(53 + 9 * x + y) : 8'(16 * y + x);
    endcase
  endfunction

  // Called right after the lo byte is driven: the write is due next cycle.
  task automatic push_px(input int x, input int y, input logic [7:0] hi, input logic [7:0] lo,
                         input int pat);
    logic [11:0] x12;
    logic [15:0] x16;
    if (!cap || x >= H || y >= V || (x % s_div) != 0 || (y % s_div) != 0) return;
    x12 = (pat == 0) ? 12'hF0F : {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    x16 = (pat == 2) ? 16'hABCD : {hi, lo};
    exp12_q.push_back({32'(cyc + 1), 19'(exp_addr), 4'h0, x12});
    exp16_q.push_back({32'(cyc + 1), 19'(exp_addr), x16});
    exp_addr++;
  endtask

  // VSYNC pulse: ends the current frame (if captured) and starts the next.
  task automatic vsync_pulse(input bit h1, input bit exp_done, input bit next_cap);
    drive(1'b1, h1, 8'h55);
    cap = 1'b0;
    if (exp_done) begin fc = fc + 16'd1; fd_exp++; end
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk); #1;
    check("pending12", exp12_q.size(), 0);
    check("pending16", exp16_q.size(), 0);
    check("frame_done12", fd12, exp_done);
    check("frame_done16", fd16, exp_done);
    check("frame_count12", fc12, fc);
    check("frame_count16", fc16, fc);
    check("line_err12", le12, le);
    check("line_err16", le16, le);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("frame_done_width12", fd12, 1'b0);
    s_div = (scale == 2'd1) ? 2 : (scale == 2'd2) ? 4 : 1;
    drive(1'b0, 1'b0, 8'h00);
    cap = next_cap;
    if (next_cap) exp_addr = 0;
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("state12", st12, next_cap ? 2'd2 : 2'd0);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic lines(input int y0, input int n, input int short_line, input int short_len,
                       input int rst_byte, input int trunc_len, input int pat);
    logic [7:0] b, hi;
    int len;
    bit trunc;
    hi = 8'h00;
    for (int y = y0; y < y0 + n; y++) begin
      trunc = (trunc_len > 0) && (y == y0 + n - 1);
      len   = (y == short_line) ? short_len : 2 * H;
      if (trunc) len = trunc_len;
      for (int i = 0; i < len; i++) begin
        b = pat_byte(pat, y, i / 2, i % 2);
        drive(1'b0, 1'b1, b);
        if (i % 2 == 0) hi = b;
        else push_px(i / 2, y, hi, b, pat);
        if (rst_byte >= 0 && y == 0 && i == rst_byte + 1) begin
          reset = 1'b1;
          cap   = 1'b0;
        end
        if (rst_byte >= 0 && y == 0 && i == rst_byte + 2) begin
          reset = 1'b0;
          fc = 16'd0; le = 1'b0; exp_addr = 0;
          @(negedge clk);
          check("rst_we12", we12, 1'b0);
          check("rst_we16", we16, 1'b0);
          check("rst_addr12", addr12, 0);
          check("rst_addr16", addr16, 0);
          check("rst_fc12", fc12, 0);
          check("rst_fc16", fc16, 0);
          check("rst_state12", st12, 2'd0);
        end
      end
      if (!trunc) begin
        if (cap && len != 2 * H) le = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00; scale = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_we12", we12, 1'b0);
    check("reset_addr12", addr12, 0);
    check("reset_dout12", dout12, 0);
    check("reset_dout16", dout16, 0);
    check("reset_fd12", fd12, 1'b0);
    check("reset_fc12", fc12, 0);
    check("reset_le12", le12, 1'b0);
    check("reset_state12", st12, 2'd0);
    enable = 1'b1;

    // Full-scale frame of 0xF8,0x1F: 32 writes of 0xF0F / 0xF81F
    scale = 2'd0; vsync_pulse(1'b0, 1'b0, 1'b1);
    lines(0, 4, -1, 0, -1, 0, 0);
    // Half scale: 8 writes, 4 cycles apart within a line
    scale = 2'd1; vsync_pulse(1'b0, 1'b1, 1'b1);
    lines(0, 4, -1, 0, -1, 0, 1);
    // Line 1 carries only 14 bytes
    scale = 2'd0; vsync_pulse(1'b0, 1'b1, 1'b1);
    lines(0, 4, 1, 14, -1, 0, 1);
    // Clean frame with scale=3 (full); enable dropped mid-frame
    scale = 2'd3; vsync_pulse(1'b0, 1'b1, 1'b1);
    lines(0, 2, -1, 0, -1, 0, 1);
    enable = 1'b0;
    lines(2, 2, -1, 0, -1, 0, 1);
    // Not captured; enable raised mid-frame has no effect
    vsync_pulse(1'b0, 1'b1, 1'b0);
    lines(0, 2, -1, 0, -1, 0, 1);
    enable = 1'b1;
    lines(2, 2, -1, 0, -1, 0, 1);
    // Captured; reset pulse after the 5th write
    scale = 2'd0; vsync_pulse(1'b0, 1'b0, 1'b1);
    lines(0, 4, -1, 0, 9, 0, 1);
    // Capture resumes at addr 0 after a full VSYNC pulse; 0xAB,0xCD
    vsync_pulse(1'b0, 1'b0, 1'b1);
    lines(0, 4, -1, 0, -1, 0, 2);
    // Frame truncated by VSYNC while HREF is high; counter near the limit
    vsync_pulse(1'b0, 1'b1, 1'b1);
    force dut12.frame_count = 16'hFFFF;
    force dut16.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut12.frame_count;
    release dut16.frame_count;
    fc = 16'hFFFF;
    lines(0, 2, -1, 0, -1, 5, 1);
    // Quarter scale back-to-back frames across the wrap
    scale = 2'd2; vsync_pulse(1'b1, 1'b1, 1'b1);
    lines(0, 4, -1, 0, -1, 0, 1);
    vsync_pulse(1'b0, 1'b1, 1'b1);

    #1;
    check("frame_done_total12", fd_seen12, fd_exp);
    check("frame_done_total16", fd_seen16, fd_exp);
    check("leftover12", exp12_q.size(), 0);
    check("leftover16", exp16_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_scaled.md
# ov7670_capture_scaled

Parametrised OV7670 pixel-capture engine in the camera PCLK domain, sitting between the sensor data pins and the frame-buffer write port. Assembles RGB565 byte pairs into 12- or 16-bit pixels. Optionally decimates by 2 or 4 on both axes and produces dense, linear frame-buffer addresses. Adds frame-boundary arming, a frame counter, a frame-done pulse and line-length error detection.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line (2*H_ACTIVE bytes per href).
- V_ACTIVE, 480, active lines per frame.
- OUT_BITS, 12, pixel width; 12 = RGB444, 16 = RGB565; other values illegal.
- ADDR_W, 19, address width; must hold H_ACTIVE*V_ACTIVE-1.

Ports:
- clk  in  1  camera PCLK; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture arm; sampled only at frame boundaries.
- scale  in  2  0 = full, 1 = 1/2, 2 = 1/4 per axis, 3 = treated as 0; latched at frame start.
- vsync  in  1  sensor VSYNC, high between frames.
- href  in  1  sensor HREF, high during active line bytes.
- d  in  8  sensor data byte.
- we  out  1  frame-buffer write strobe.
- addr  out  ADDR_W  write address.
- dout  out  OUT_BITS  write pixel.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- frame_count  out  16  captured frames, wraps 65535->0.
- line_err  out  1  sticky; a line did not carry exactly 2*H_ACTIVE bytes.

## Operation
- States: IDLE, SYNC, ACTIVE. Reset -> IDLE.
- IDLE: if enable=1 and vsync=1, go to SYNC. A frame already in progress is never captured.
- SYNC: on a vsync falling edge (vsync_q=1, vsync=0):
  - latch scale into S (1/2/4);
  - clear x, y, byte phase, byte count and write address;
  - go to ACTIVE.
- ACTIVE, while href=1, on each cycle:
  - phase 0 stores d as hi byte;
  - phase 1 forms pixel {hi,d}, increments x and toggles phase.
- Write on phase 1 only if x<H_ACTIVE, y<V_ACTIVE, x mod S = 0 and y mod S = 0. The write counter then increments, so addresses are dense 0..(H_ACTIVE/S)*(V_ACTIVE/S)-1.
- On an href falling edge:
  - if byte count ≠ 2*H_ACTIVE, set line_err;
  - y++; clear x, phase and byte count.
  - An odd trailing byte is discarded.
- On a vsync rising edge in ACTIVE:
  - pulse frame_done, frame_count++;
  - discard any pending half pixel;
  - next state is SYNC if enable=1, else IDLE.
- Pixel format: hi = {R[4:0],G[5:3]}, lo = {G[2:0],B[4:0]}.
  - OUT_BITS=16: dout = {hi,lo}.
  - OUT_BITS=12: dout = {R[4:1],G[5:2],B[4:1]}.
- enable changes inside a frame have no effect until that frame ends.
- line_err clears only on reset.

## Timing
- All outputs are registered. Reset values: we=0, addr=0, dout=0, frame_done=0, frame_count=0, line_err=0, state IDLE.
- Latency: lo byte on d in cycle k -> we=1 with matching addr/dout in cycle k+1. we is high for exactly one cycle per written pixel.
- Edge detection uses a one-cycle registered copy of vsync/href. A vsync rise first seen in cycle k gives frame_done=1 and the incremented frame_count in cycle k+1.
- vsync rise while href=1: the frame ends, no write for the partial pixel, and no line_err for the truncated line.
- Reset asserted mid-frame: outputs go to reset values the next cycle, and the state returns to IDLE. The next capture starts only after a full vsync pulse, at addr 0.
- Scale is constant for a whole frame.

## Test plan
Bench parameters: H_ACTIVE=8, V_ACTIVE=4.
- Full frame, OUT_BITS=12, scale=0, every pixel 0xF8,0x1F -> 32 writes, addr 0..31, dout=0xF0F, one frame_done, frame_count=1, line_err=0.
- scale=1, 4 lines of 16 bytes -> 8 writes at addr 0..7. Writes come only from even x of lines 0 and 2; we is spaced 4 cycles apart.
- Line 1 carries 14 bytes -> line_err=1 and stays 1 through the next clean frame. Line 1 writes 7 pixels and the next line starts at the correct dense addr.
- enable raised while vsync=0 mid-frame -> no writes until after the next vsync high->low. Dropping enable mid-frame still completes that frame, then returns to IDLE.
- Reset pulse after the 5th write -> we=0/addr=0/frame_count=0 next cycle, no writes for the rest of that frame. The following frame writes addr 0..31.
- OUT_BITS=16, bytes 0xAB,0xCD -> dout=0xABCD one cycle after 0xCD. Back-to-back frames wrap frame_count 65535->0 when forced near the limit.
